// File: rtl/reg_file_pkg.sv
// Shared types and constants for the two-requester register file arbiter.
package reg_file_pkg;

    localparam int N_REQ = 2;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED0  = 2'd1,
        LOCKED1  = 2'd2
    } state_t;

    function automatic logic other_req(input logic idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way pick: masked requesters, round-robin pointer breaks ties.
module rr_arbiter2
    import reg_file_pkg::*;
(
    input  logic [N_REQ-1:0] valid,
    input  logic             rr,
    input  logic [N_REQ-1:0] mask,
    output logic [N_REQ-1:0] grant
);

    logic [N_REQ-1:0] eligible_s;

    // one-hot grant from the eligible set
    always_comb begin
        eligible_s = valid & mask;
        grant      = 2'b00;
        case (eligible_s)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/reg_file_arbiter.sv
// Arbitrates two requesters onto one register file port, with optional exclusive
// locking, idle-timeout release and a one-cycle registered response path.
module reg_file_arbiter
    import reg_file_pkg::*;
#(
    parameter  int WIDTH    = 8,
    parameter  int N_REG    = 8,
    parameter  int LOCK_MAX = 4,
    localparam int AW       = $clog2(N_REG)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ-1:0]             req_we,
    input  logic [N_REQ-1:0]             req_lock,
    input  logic [N_REQ-1:0][AW-1:0]     req_addr,
    input  logic [N_REQ-1:0][WIDTH-1:0]  req_wdata,
    output logic [N_REQ-1:0]             rsp_valid,
    output logic [WIDTH-1:0]             rsp_data,
    output logic                         rsp_err,
    output logic [AW-1:0]                rf_a,
    output logic                         rf_ce,
    output logic [WIDTH-1:0]             rf_in,
    input  logic [WIDTH-1:0]             rf_out
);

    localparam int            CW        = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_MAX - 1);
    localparam logic [AW-1:0] USER_REG  = AW'(N_REG - 1);

    state_t            state_q, state_d;
    logic              rr_q, rr_d;
    logic [CW-1:0]     idle_cnt_q, idle_cnt_d;
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    logic [N_REQ-1:0]  mask_s, grant_s, accept_s;
    logic              any_acc_s, sel_s, owner_s;

    rr_arbiter2 u_pick (
        .valid (req_valid),
        .rr    (rr_q),
        .mask  (mask_s),
        .grant (grant_s)
    );

    // state, pointer, idle counter and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= UNLOCKED;
            rr_q        <= 1'b0;
            idle_cnt_q  <= '0;
            rsp_valid_q <= 2'b00;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            idle_cnt_q  <= idle_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // next state: lock ownership, round-robin pointer and idle timeout
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        idle_cnt_d = idle_cnt_q;
        owner_s    = (state_q == LOCKED1);
        case (state_q)
            UNLOCKED: begin
                if (any_acc_s) begin
                    rr_d       = other_req(sel_s);
                    idle_cnt_d = '0;
                    if (req_lock[sel_s]) begin
                        state_d = sel_s ? LOCKED1 : LOCKED0;
                    end else begin
                        state_d = UNLOCKED;
                    end
                end else begin
                    idle_cnt_d = '0;
                end
            end
            LOCKED0, LOCKED1: begin
                if (accept_s[owner_s]) begin
                    idle_cnt_d = '0;
                    if (!req_lock[owner_s]) begin
                        state_d = UNLOCKED;
                        rr_d    = other_req(owner_s);
                    end else begin
                        state_d = state_q;
                    end
                end else if (idle_cnt_q == LOCK_LAST) begin
                    // timeout hands the port to the waiting side on this same edge
                    idle_cnt_d = '0;
                    state_d    = UNLOCKED;
                    rr_d       = other_req(owner_s);
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = UNLOCKED;
                rr_d       = 1'b0;
                idle_cnt_d = '0;
            end
        endcase
    end

    // outputs: grant mask, register file port and response capture
    always_comb begin
        case (state_q)
            UNLOCKED: mask_s = 2'b11;
            LOCKED0:  mask_s = 2'b01;
            LOCKED1:  mask_s = 2'b10;
            default:  mask_s = 2'b11;
        endcase
        req_ready = rst ? 2'b00 : grant_s;
        accept_s  = req_valid & req_ready;
        any_acc_s = |accept_s;
        sel_s     = accept_s[1];

        if (any_acc_s) begin
            rf_a  = req_addr[sel_s];
            rf_in = req_wdata[sel_s];
            rf_ce = req_we[sel_s] & (req_addr[sel_s] != USER_REG);
        end else begin
            rf_a  = '0;
            rf_in = '0;
            rf_ce = 1'b0;
        end

        rsp_valid_d = accept_s;
        if (any_acc_s) begin
            rsp_data_d = req_we[sel_s] ? req_wdata[sel_s] : rf_out;
            rsp_err_d  = req_we[sel_s] & (req_addr[sel_s] == USER_REG);
        end else begin
            rsp_data_d = rsp_data_q;
            rsp_err_d  = 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Directed bench for reg_file_arbiter with a small behavioural register file.
module tb_reg_file_arbiter;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid, req_ready, req_we, req_lock;
    logic [1:0][2:0] req_addr;
    logic [1:0][7:0] req_wdata;
    logic [1:0]      rsp_valid;
    logic [7:0]      rsp_data;
    logic            rsp_err;
    logic [2:0]      rf_a;
    logic            rf_ce;
    logic [7:0]      rf_in;
    logic [7:0]      rf_out;
    logic [7:0]      mem [8];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_file_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .rf_a(rf_a), .rf_ce(rf_ce), .rf_in(rf_in), .rf_out(rf_out)
    );

    assign rf_out = mem[rf_a];
    always @(posedge clk) if (rf_ce) mem[rf_a] <= rf_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_rdy [4];
        logic [1:0] lk      [4];
        for (int i = 0; i < 8; i++) mem[i] = 8'h30 + 8'(i);
        rst = 1'b1;
        req_valid = 2'b11; req_we = 2'b00; req_lock = 2'b00;
        req_addr = '0; req_wdata = '0;
        tick(); tick();
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        chk("rst_rf_ce", 32'(rf_ce), 32'h0);

        // alternating reads, first grant right after reset release
        rst = 1'b0;
        req_addr[0] = 3'd3; req_addr[1] = 3'd5;
        #1;
        chk("alt_ready0", 32'(req_ready), 32'h1);
        chk("alt_rf_a0", 32'(rf_a), 32'h3);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("alt_rsp_valid", 32'(rsp_valid), (k % 2 == 1) ? 32'h1 : 32'h2);
            chk("alt_rsp_data", 32'(rsp_data), (k % 2 == 1) ? 32'h33 : 32'h35);
            chk("alt_ready", 32'(req_ready), (k % 2 == 1) ? 32'h2 : 32'h1);
        end
        req_valid = 2'b00;
        tick();

        // write then read-after-write
        req_valid = 2'b01; req_we = 2'b01; req_addr[0] = 3'd2; req_wdata[0] = 8'hA5;
        #1;
        chk("wr_ready", 32'(req_ready), 32'h1);
        chk("wr_rf_ce", 32'(rf_ce), 32'h1);
        chk("wr_rf_a", 32'(rf_a), 32'h2);
        chk("wr_rf_in", 32'(rf_in), 32'hA5);
        tick();
        chk("wr_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("wr_rsp_data", 32'(rsp_data), 32'hA5);
        chk("wr_rsp_err", 32'(rsp_err), 32'h0);
        req_valid = 2'b10; req_we = 2'b00; req_addr[1] = 3'd2;
        #1;
        chk("raw_ready", 32'(req_ready), 32'h2);
        chk("raw_rf_ce", 32'(rf_ce), 32'h0);
        tick();
        chk("raw_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("raw_rsp_data", 32'(rsp_data), 32'hA5);

        // write to the user-input register is refused
        req_valid = 2'b10; req_we = 2'b10; req_addr[1] = 3'd7; req_wdata[1] = 8'h3C;
        #1;
        chk("uw_ready", 32'(req_ready), 32'h2);
        chk("uw_rf_ce", 32'(rf_ce), 32'h0);
        tick();
        chk("uw_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("uw_rsp_err", 32'(rsp_err), 32'h1);
        chk("uw_rsp_data", 32'(rsp_data), 32'h3C);
        req_valid = 2'b00; req_we = 2'b00;
        tick();
        chk("idle_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("idle_rsp_err", 32'(rsp_err), 32'h0);
        chk("idle_rsp_hold", 32'(rsp_data), 32'h3C);
        chk("uw_mem7", 32'(mem[7]), 32'h37);

        // lock then idle timeout
        req_valid = 2'b11; req_lock = 2'b01; req_addr[0] = 3'd1; req_addr[1] = 3'd4;
        #1;
        chk("lk_ready", 32'(req_ready), 32'h1);
        tick();
        chk("lk_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("lk_rsp_data", 32'(rsp_data), 32'h31);
        req_valid = 2'b10; req_lock = 2'b00;
        for (int c = 1; c <= 4; c++) begin
            #1;
            chk("lk_blocked", 32'(req_ready), 32'h0);
            tick();
        end
        #1;
        chk("lk_timeout_grant", 32'(req_ready), 32'h2);
        tick();
        chk("lk_r1_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("lk_r1_rsp_data", 32'(rsp_data), 32'h34);

        // lock, lock, unlock with r1 waiting
        exp_rdy[0] = 2'b01; exp_rdy[1] = 2'b01; exp_rdy[2] = 2'b01; exp_rdy[3] = 2'b10;
        lk[0] = 2'b01; lk[1] = 2'b01; lk[2] = 2'b00; lk[3] = 2'b00;
        req_valid = 2'b11; req_addr[0] = 3'd0;
        for (int c = 0; c < 4; c++) begin
            req_lock = lk[c];
            #1;
            chk("lul_ready", 32'(req_ready), 32'(exp_rdy[c]));
            tick();
        end
        req_valid = 2'b00; req_lock = 2'b00;
        tick();

        // reset while LOCKED1 with a read in flight
        req_valid = 2'b10; req_lock = 2'b10; req_addr[1] = 3'd6;
        #1;
        chk("l1_ready", 32'(req_ready), 32'h2);
        tick();
        req_addr[1] = 3'd5;
        #1;
        chk("l1_hold_ready", 32'(req_ready), 32'h2);
        #2;
        rst = 1'b1;
        #1;
        chk("l1_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        tick();
        chk("l1_rst_edge_rsp_valid", 32'(rsp_valid), 32'h0);
        rst = 1'b0; req_valid = 2'b11; req_lock = 2'b00; req_addr[0] = 3'd3;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        tick();
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("post_rst_rsp_data", 32'(rsp_data), 32'h33);
        req_valid = 2'b00;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_arbiter.md
REG_FILE_ARBITER -- requirements
Module: reg_file_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of the shared register file.
REQ-002 SHALL have parameter N_REG, default 8, register count; index N_REG-1 is the external user-input register; AW = $clog2(N_REG).
REQ-003 SHALL have parameter LOCK_MAX, default 4, idle cycles after which a held lock is force-released.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; asynchronous and active-high.
REQ-006 req_valid  input  [1:0]  per-requester transaction valid.
REQ-007 req_ready  output  [1:0]  per-requester grant; a transaction is accepted when valid & ready.
REQ-008 req_we  input  [1:0]  1 = write, 0 = read.
REQ-009 req_lock  input  [1:0]  keep exclusive ownership after this transaction.
REQ-010 req_addr  input  [1:0][AW-1:0]  register index.
REQ-011 req_wdata  input  [1:0][WIDTH-1:0]  write data.
REQ-012 rsp_valid  output  [1:0]  one-cycle response pulse.
REQ-013 rsp_data  output  [WIDTH-1:0]  read data, or write data echoed for writes.
REQ-014 rsp_err  output  1  qualifies rsp_valid: write targeted N_REG-1.
REQ-015 rf_a  output  [AW-1:0]  register file address.
REQ-016 rf_ce  output  1  register file write enable.
REQ-017 rf_in  output  [WIDTH-1:0]  register file write data.
REQ-018 rf_out  input  [WIDTH-1:0]  register file combinational read data.

Function
REQ-019 SHALL assert at most one req_ready bit per cycle; req_ready depends on req_valid, state and pointer only, never on addr/we/wdata.
REQ-020 State UNLOCKED: sole valid requester is granted; both valid -> requester indicated by round-robin pointer rr granted.
REQ-021 On every accept in UNLOCKED, rr SHALL move to the non-granted requester.
REQ-022 Accept with req_lock=1 -> next state LOCKED_i (i = granted requester); in LOCKED_i only requester i may be granted, the other sees ready=0.
REQ-023 In LOCKED_i, accept with req_lock=0 -> UNLOCKED, rr = other requester.
REQ-024 In LOCKED_i, idle counter SHALL increment each cycle without accept from i, clear on accept; on reaching LOCKED_MAX -> UNLOCKED, rr = other requester, same edge.
REQ-025 Accepted cycle: rf_a = req_addr[i]; rf_in = req_wdata[i]; rf_ce = req_we[i] & (req_addr[i] != N_REG-1).
REQ-026 No accept: rf_a = 0, rf_in = 0, rf_ce = 0.
REQ-027 Read accepted in cycle N: rsp_data SHALL hold rf_out sampled in cycle N, rsp_valid[i]=1 in cycle N+1 only.
REQ-028 Write accepted in cycle N: rsp_valid[i]=1 in N+1, rsp_data = written data, rsp_err = (addr == N_REG-1); write to N_REG-1 SHALL never assert rf_ce.
REQ-029 rsp_err SHALL be 0 whenever rsp_valid is 0 or for reads; rsp_data holds its last value when rsp_valid is 0.
REQ-030 Throughput: one accept per cycle, back-to-back, no bubbles; responses have no backpressure.
REQ-031 Read in cycle N+1 of a register written in cycle N SHALL return the new value.

Reset
REQ-032 While rst=1: state UNLOCKED, rr = requester 0, idle counter 0, rsp_valid = 0, rsp_err = 0, rsp_data = 0, rf_ce = 0, req_ready = 0.
REQ-033 Reset asserted mid-lock or with a response pending SHALL discard both; no rsp_valid after release for pre-reset accepts.
REQ-034 First grant is possible in the first cycle with rst=0.

Structure
REQ-035 Package reg_file_pkg SHALL hold the state enum (UNLOCKED, LOCKED0, LOCKED1) and the requester count constant (2).
REQ-036 Sub-module rr_arbiter2 (valid[1:0], rr, mask -> one-hot grant) SHALL implement the combinational pick; state, counter and response registers stay in reg_file_arbiter.

Verification
REQ-037 Both valid reads addr 3 (r0) and 5 (r1) continuously from reset -> grants alternate 0,1,0,1; each rsp_valid one cycle after its accept with matching data.
REQ-038 r0 writes 0xA5 to addr 2, next cycle r1 reads addr 2 -> rf_ce one cycle, r1 rsp_data = 0xA5.
REQ-039 r1 writes 0x3C to addr N_REG-1 -> rf_ce stays 0, rsp_valid[1]=1 with rsp_err=1, rsp_data = 0x3C.
REQ-040 r0 lock read, then idles 4 cycles while r1 valid -> r1 ready=0 for 4 cycles, granted in 5th cycle.
REQ-041 r0 lock, lock, unlock sequence with r1 valid -> r0 granted 3 consecutive, then r1.
REQ-042 rst pulsed in LOCKED1 with read pending -> no rsp_valid after reset; r0 granted first when both valid.
